// File: rtl/systolic_job_scheduler.sv
// systolic_job_scheduler
//
// Buffers matrix-multiply job descriptors from the host in a small FIFO and runs
// them one at a time on the systolic core: it pops a descriptor, drives it to the
// core with a one-cycle new_data pulse, waits for a rising edge of core_done, and
// hands back a completion record over a valid/ready port.
//
// Optional feature: define SCHED_TIMEOUT_EN to add a RUN-state watchdog that aborts
// the core after TIMEOUT cycles and reports the job with cmp_timeout set.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   job_valid/job_ready            host job handshake (ready while FIFO not full)
//   job_addr_A/B/C, job_n          job descriptor
//   new_data, addr_A/B/C, n        start pulse and registered descriptor to the core
//   core_done, core_total_cycles,
//   core_overflow                  core completion and status
//   core_abort                     one-cycle abort request to the core (watchdog)
//   cmp_valid/cmp_ready            completion record handshake
//   cmp_id, cmp_cycles,
//   cmp_overflow, cmp_error,
//   cmp_timeout                    completion record fields
//   busy, queue_count, jobs_done   status
module systolic_job_scheduler #(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 12,
    parameter int N       = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  job_valid,
    output logic                  job_ready,
    input  logic [ADDR_W-1:0]     job_addr_A,
    input  logic [ADDR_W-1:0]     job_addr_B,
    input  logic [ADDR_W-1:0]     job_addr_C,
    input  logic [3:0]            job_n,
    output logic                  new_data,
    output logic [ADDR_W-1:0]     addr_A,
    output logic [ADDR_W-1:0]     addr_B,
    output logic [ADDR_W-1:0]     addr_C,
    output logic [3:0]            n,
    input  logic                  core_done,
    input  logic [15:0]           core_total_cycles,
    input  logic                  core_overflow,
    output logic                  core_abort,
    output logic                  cmp_valid,
    input  logic                  cmp_ready,
    output logic [3:0]            cmp_id,
    output logic [15:0]           cmp_cycles,
    output logic                  cmp_overflow,
    output logic                  cmp_error,
    output logic                  cmp_timeout,
    output logic                  busy,
    output logic [$clog2(DEPTH):0] queue_count,
    output logic [15:0]           jobs_done
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [4:0]    N_MAX      = 5'(N);

    typedef enum logic [1:0] {StIdle, StIssue, StRun, StReport} state_e;

    // FIFO storage; the job id travels with its descriptor.
    logic [ADDR_W-1:0] r_mem_a  [DEPTH];
    logic [ADDR_W-1:0] r_mem_b  [DEPTH];
    logic [ADDR_W-1:0] r_mem_c  [DEPTH];
    logic [3:0]        r_mem_n  [DEPTH];
    logic [3:0]        r_mem_id [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [3:0]        r_next_id;

    state_e            r_state;
    logic              r_done_q;
    logic              r_new_data;
    logic [ADDR_W-1:0] r_addr_a;
    logic [ADDR_W-1:0] r_addr_b;
    logic [ADDR_W-1:0] r_addr_c;
    logic [3:0]        r_n;
    logic [3:0]        r_id;
    logic              r_cmp_valid;
    logic [15:0]       r_cmp_cycles;
    logic              r_cmp_overflow;
    logic              r_cmp_error;
    logic [15:0]       r_jobs_done;

    logic w_push;
    logic w_pop;
    logic w_head_bad;
    logic w_done_edge;

    assign job_ready   = (r_count < FULL_COUNT);
    assign w_push      = job_valid && job_ready;
    assign w_pop       = (r_state == StIdle) && (r_count != '0);
    assign w_head_bad  = (r_mem_n[r_rd_ptr] == 4'd0) || ({1'b0, r_mem_n[r_rd_ptr]} > N_MAX);
    // Only a fresh edge counts, so a done level left over from the last job is ignored.
    assign w_done_edge = core_done && !r_done_q;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr]  <= job_addr_A;
            r_mem_b[r_wr_ptr]  <= job_addr_B;
            r_mem_c[r_wr_ptr]  <= job_addr_C;
            r_mem_n[r_wr_ptr]  <= job_n;
            r_mem_id[r_wr_ptr] <= r_next_id;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_next_id <= 4'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr  <= r_wr_ptr + 1'b1;
                r_next_id <= r_next_id + 4'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef SCHED_TIMEOUT_EN
    localparam logic [15:0] WD_LIMIT    = 16'(TIMEOUT - 1);
    localparam logic [15:0] TIMEOUT_CYC = 16'(TIMEOUT);
    logic [15:0] r_wd_cnt;
    logic        r_abort;
    logic        r_cmp_timeout;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= StIdle;
            r_done_q       <= 1'b0;
            r_new_data     <= 1'b0;
            r_addr_a       <= '0;
            r_addr_b       <= '0;
            r_addr_c       <= '0;
            r_n            <= 4'd0;
            r_id           <= 4'd0;
            r_cmp_valid    <= 1'b0;
            r_cmp_cycles   <= 16'd0;
            r_cmp_overflow <= 1'b0;
            r_cmp_error    <= 1'b0;
            r_jobs_done    <= 16'd0;
`ifdef SCHED_TIMEOUT_EN
            r_wd_cnt       <= 16'd0;
            r_abort        <= 1'b0;
            r_cmp_timeout  <= 1'b0;
`endif
        end else begin
            r_done_q <= core_done;
`ifdef SCHED_TIMEOUT_EN
            r_abort  <= 1'b0;
`endif
            case (r_state)
                StIdle: begin
                    if (w_pop) begin
                        r_addr_a <= r_mem_a[r_rd_ptr];
                        r_addr_b <= r_mem_b[r_rd_ptr];
                        r_addr_c <= r_mem_c[r_rd_ptr];
                        r_n      <= r_mem_n[r_rd_ptr];
                        r_id     <= r_mem_id[r_rd_ptr];
                        if (w_head_bad) begin
                            // Illegal size: report straight away without touching the core.
                            r_cmp_valid    <= 1'b1;
                            r_cmp_error    <= 1'b1;
                            r_cmp_cycles   <= 16'd0;
                            r_cmp_overflow <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
                            r_cmp_timeout  <= 1'b0;
`endif
                            r_state        <= StReport;
                        end else begin
                            r_new_data <= 1'b1;
                            r_state    <= StIssue;
                        end
                    end
                end
                StIssue: begin
                    r_new_data <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
                    r_wd_cnt   <= 16'd0;
`endif
                    r_state    <= StRun;
                end
                StRun: begin
                    if (w_done_edge) begin
                        r_cmp_valid    <= 1'b1;
                        r_cmp_error    <= 1'b0;
                        r_cmp_cycles   <= core_total_cycles;
                        r_cmp_overflow <= core_overflow;
`ifdef SCHED_TIMEOUT_EN
                        r_cmp_timeout  <= 1'b0;
`endif
                        r_state        <= StReport;
                    end
`ifdef SCHED_TIMEOUT_EN
                    else if (r_wd_cnt == WD_LIMIT) begin
                        r_abort        <= 1'b1;
                        r_cmp_valid    <= 1'b1;
                        r_cmp_error    <= 1'b0;
                        r_cmp_cycles   <= TIMEOUT_CYC;
                        r_cmp_overflow <= 1'b0;
                        r_cmp_timeout  <= 1'b1;
                        r_state        <= StReport;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 16'd1;
                    end
`endif
                end
                StReport: begin
                    if (cmp_ready) begin
                        r_cmp_valid <= 1'b0;
                        r_jobs_done <= r_jobs_done + 16'd1;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

`ifdef SCHED_TIMEOUT_EN
    assign core_abort  = r_abort;
    assign cmp_timeout = r_cmp_timeout;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT;
    assign core_abort       = 1'b0;
    assign cmp_timeout      = 1'b0;
`endif

    assign new_data     = r_new_data;
    assign addr_A       = r_addr_a;
    assign addr_B       = r_addr_b;
    assign addr_C       = r_addr_c;
    assign n            = r_n;
    assign cmp_valid    = r_cmp_valid;
    assign cmp_id       = r_id;
    assign cmp_cycles   = r_cmp_cycles;
    assign cmp_overflow = r_cmp_overflow;
    assign cmp_error    = r_cmp_error;
    assign busy         = (r_state != StIdle) || (r_count != '0);
    assign queue_count  = r_count;
    assign jobs_done    = r_jobs_done;

endmodule

// File: tb/tb_systolic_job_scheduler.sv
// tb_systolic_job_scheduler
//
// Self-checking bench for systolic_job_scheduler. A behavioural core model answers
// new_data pulses with core_done after a programmable latency; every accepted job
// pushes its expected completion record onto a scoreboard queue, which is popped and
// compared whenever a cmp_valid/cmp_ready handshake is seen. All stimulus, model and
// monitor activity runs in one process, stepped through tick().
`timescale 1ns/1ps
module tb_systolic_job_scheduler;
    localparam int DEPTH   = 4;
    localparam int ADDR_W  = 12;
    localparam int N       = 4;
    localparam int TIMEOUT = 64;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  job_valid = 1'b0;
    logic                  job_ready;
    logic [ADDR_W-1:0]     job_addr_A = '0;
    logic [ADDR_W-1:0]     job_addr_B = '0;
    logic [ADDR_W-1:0]     job_addr_C = '0;
    logic [3:0]            job_n = 4'd0;
    logic                  new_data;
    logic [ADDR_W-1:0]     addr_A;
    logic [ADDR_W-1:0]     addr_B;
    logic [ADDR_W-1:0]     addr_C;
    logic [3:0]            n;
    logic                  core_done = 1'b0;
    logic [15:0]           core_total_cycles = 16'd0;
    logic                  core_overflow = 1'b0;
    logic                  core_abort;
    logic                  cmp_valid;
    logic                  cmp_ready = 1'b1;
    logic [3:0]            cmp_id;
    logic [15:0]           cmp_cycles;
    logic                  cmp_overflow;
    logic                  cmp_error;
    logic                  cmp_timeout;
    logic                  busy;
    logic [$clog2(DEPTH):0] queue_count;
    logic [15:0]           jobs_done;

    systolic_job_scheduler #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .N       (N),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .job_valid         (job_valid),
        .job_ready         (job_ready),
        .job_addr_A        (job_addr_A),
        .job_addr_B        (job_addr_B),
        .job_addr_C        (job_addr_C),
        .job_n             (job_n),
        .new_data          (new_data),
        .addr_A            (addr_A),
        .addr_B            (addr_B),
        .addr_C            (addr_C),
        .n                 (n),
        .core_done         (core_done),
        .core_total_cycles (core_total_cycles),
        .core_overflow     (core_overflow),
        .core_abort        (core_abort),
        .cmp_valid         (cmp_valid),
        .cmp_ready         (cmp_ready),
        .cmp_id            (cmp_id),
        .cmp_cycles        (cmp_cycles),
        .cmp_overflow      (cmp_overflow),
        .cmp_error         (cmp_error),
        .cmp_timeout       (cmp_timeout),
        .busy              (busy),
        .queue_count       (queue_count),
        .jobs_done         (jobs_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]        id;
        logic [15:0]       cycles;
        logic              ovf;
        logic              err;
        logic              tmo;
        logic [ADDR_W-1:0] c;
        logic [3:0]        n;
    } exp_t;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] b;
        logic [ADDR_W-1:0] c;
        logic [3:0]        n;
        int                lat;
        logic [15:0]       rep;
        logic              ovf;
        logic              exp_err;
        logic [15:0]       exp_cycles;
        logic              exp_ovf;
    } vec_t;

    exp_t       sb_q[$];
    vec_t       vecs[7];
    int         checks = 0;
    int         errors = 0;
    int         n_pulses = 0;
    int         n_aborts = 0;
    int         tb_jobs = 0;
    logic [3:0] tb_next_id = 4'd0;

    // Core model state.
    int          cd = 0;
    int          model_lat = 10;
    logic [15:0] model_rep = 16'd10;
    logic        model_ovf = 1'b0;
    logic        model_hold = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            cd = 0;
            core_done = 1'b0;
        end else if (new_data) begin
            cd = model_lat;
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                core_done = 1'b1;
                core_total_cycles = model_rep;
                core_overflow = model_ovf;
            end else if (model_hold && cd == model_lat / 2) begin
                // Drop a held level mid-job so the next rise is a genuine edge.
                core_done = 1'b0;
            end
        end else if (!model_hold) begin
            core_done = 1'b0;
        end
    endtask

    task automatic monitor_step();
        exp_t e;
        if (new_data) n_pulses++;
        if (core_abort) n_aborts++;
        if (cmp_valid && cmp_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_record: got id %0d, want no record", cmp_id);
            end else begin
                e = sb_q.pop_front();
                check("cmp_id", 32'(cmp_id), 32'(e.id));
                check("cmp_cycles", 32'(cmp_cycles), 32'(e.cycles));
                check("cmp_overflow", 32'(cmp_overflow), 32'(e.ovf));
                check("cmp_error", 32'(cmp_error), 32'(e.err));
                check("cmp_timeout", 32'(cmp_timeout), 32'(e.tmo));
                check("rec_addr_C", 32'(addr_C), 32'(e.c));
                check("rec_n", 32'(n), 32'(e.n));
                tb_jobs++;
            end
        end
    endtask

    // One clock: model and monitor act on the falling edge, return 1ns after the rising edge.
    task automatic tick();
        @(negedge clk);
        model_step();
        monitor_step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_job(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                            input logic [ADDR_W-1:0] c, input logic [3:0] nn,
                            input logic [15:0] exp_cycles, input logic exp_ovf,
                            input logic exp_err, input logic exp_tmo, input int bound,
                            output bit accepted);
        exp_t e;
        bit   rdy;
        accepted   = 1'b0;
        job_valid  = 1'b1;
        job_addr_A = a;
        job_addr_B = b;
        job_addr_C = c;
        job_n      = nn;
        for (int w = 0; w < bound; w++) begin
            rdy = job_ready;
            tick();
            if (rdy) begin
                accepted = 1'b1;
                break;
            end
        end
        job_valid = 1'b0;
        if (accepted) begin
            e.id = tb_next_id;
            e.cycles = exp_cycles;
            e.ovf = exp_ovf;
            e.err = exp_err;
            e.tmo = exp_tmo;
            e.c = c;
            e.n = nn;
            sb_q.push_back(e);
            tb_next_id = tb_next_id + 4'd1;
        end
    endtask

    task automatic drain(input int bound);
        bit ok;
        ok = 1'b0;
        for (int w = 0; w < bound; w++) begin
            if (sb_q.size() == 0 && !busy && !cmp_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d records pending, want 0", sb_q.size());
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_new_data"}, 32'(new_data), 32'd0);
        check({tag, "_addr_A"}, 32'(addr_A), 32'd0);
        check({tag, "_addr_B"}, 32'(addr_B), 32'd0);
        check({tag, "_addr_C"}, 32'(addr_C), 32'd0);
        check({tag, "_n"}, 32'(n), 32'd0);
        check({tag, "_core_abort"}, 32'(core_abort), 32'd0);
        check({tag, "_cmp_valid"}, 32'(cmp_valid), 32'd0);
        check({tag, "_cmp_id"}, 32'(cmp_id), 32'd0);
        check({tag, "_cmp_cycles"}, 32'(cmp_cycles), 32'd0);
        check({tag, "_cmp_flags"}, 32'({cmp_overflow, cmp_error, cmp_timeout}), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_queue_count"}, 32'(queue_count), 32'd0);
        check({tag, "_jobs_done"}, 32'(jobs_done), 32'd0);
        check({tag, "_job_ready"}, 32'(job_ready), 32'd1);
    endtask

    initial begin
        bit acc;
        int p0;
        int a0;
        int lat_cnt;

        //        a        b        c        n   lat rep       ovf   err   cycles    ovf
        vecs[0] = '{12'h010, 12'h020, 12'h030, 4'd1, 5,  16'd5,    1'b0, 1'b0, 16'd5,    1'b0};
        vecs[1] = '{12'hABC, 12'h123, 12'hFFF, 4'd4, 12, 16'd12,   1'b1, 1'b0, 16'd12,   1'b1};
        vecs[2] = '{12'h001, 12'h002, 12'h003, 4'd0, 5,  16'd99,   1'b1, 1'b1, 16'd0,    1'b0};
        vecs[3] = '{12'h100, 12'h200, 12'h300, 4'd5, 5,  16'd99,   1'b1, 1'b1, 16'd0,    1'b0};
        vecs[4] = '{12'h444, 12'h555, 12'h666, 4'd2, 1,  16'hBEEF, 1'b0, 1'b0, 16'hBEEF, 1'b0};
        vecs[5] = '{12'h7A7, 12'h8B8, 12'h9C9, 4'd15, 5, 16'd99,   1'b0, 1'b1, 16'd0,    1'b0};
        vecs[6] = '{12'h0F0, 12'h0E0, 12'h0D0, 4'd3, 7,  16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1};

        // Reset state.
        #1 rst = 1'b1;
        #1 check_reset_outputs("reset");
        tick();
        #2 rst = 1'b0;
        tick();

        // Single job with exact issue/done timing.
        model_lat = 40; model_rep = 16'd40; model_ovf = 1'b0; model_hold = 1'b0;
        p0 = n_pulses;
        push_job(12'd0, 12'd16, 12'd32, 4'd4, 16'd40, 1'b0, 1'b0, 1'b0, 10, acc);
        check("first_accept", 32'(acc), 32'd1);
        check("first_queued", 32'(queue_count), 32'd1);
        check("first_no_pulse_yet", 32'(new_data), 32'd0);
        tick();
        check("issue_pulse", 32'(new_data), 32'd1);
        check("issue_addr_C", 32'(addr_C), 32'd32);
        check("issue_n", 32'(n), 32'd4);
        check("issue_queue_empty", 32'(queue_count), 32'd0);
        tick();
        check("pulse_one_cycle", 32'(new_data), 32'd0);
        lat_cnt = 0;
        while (!cmp_valid && lat_cnt < 100) begin
            tick();
            lat_cnt++;
        end
        check("done_latency", 32'(lat_cnt), 32'd40);
        tick();
        check("report_one_cycle", 32'(cmp_valid), 32'd0);
        check("first_jobs_done", 32'(jobs_done), 32'd1);
        check("first_pulses", 32'(n_pulses - p0), 32'd1);
        drain(50);

        // Table of single jobs, each drained before the next.
        for (int i = 0; i < 7; i++) begin
            model_lat = vecs[i].lat;
            model_rep = vecs[i].rep;
            model_ovf = vecs[i].ovf;
            p0 = n_pulses;
            push_job(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].n, vecs[i].exp_cycles,
                     vecs[i].exp_ovf, vecs[i].exp_err, 1'b0, 10, acc);
            check("vec_accept", 32'(acc), 32'd1);
            drain(200);
            check("vec_pulses", 32'(n_pulses - p0), vecs[i].exp_err ? 32'd0 : 32'd1);
            check("vec_jobs_done", 32'(jobs_done), 32'(tb_jobs));
        end

        // Held done level must not complete the next job early.
        model_hold = 1'b1;
        model_lat = 10; model_rep = 16'd11; model_ovf = 1'b0;
        push_job(12'h111, 12'h222, 12'h333, 4'd2, 16'd11, 1'b0, 1'b0, 1'b0, 10, acc);
        drain(100);
        model_lat = 20; model_rep = 16'd22;
        push_job(12'h444, 12'h555, 12'h666, 4'd3, 16'd22, 1'b0, 1'b0, 1'b0, 10, acc);
        repeat (3) tick();
        check("level_no_early_done", 32'(cmp_valid), 32'd0);
        check("level_busy", 32'(busy), 32'd1);
        drain(100);
        model_hold = 1'b0;
        repeat (2) tick();

        // Reset in the middle of RUN with two jobs queued.
        model_lat = 50; model_rep = 16'd50;
        push_job(12'h00A, 12'h00B, 12'h00C, 4'd1, 16'd50, 1'b0, 1'b0, 1'b0, 10, acc);
        push_job(12'h01A, 12'h01B, 12'h01C, 4'd1, 16'd50, 1'b0, 1'b0, 1'b0, 10, acc);
        push_job(12'h02A, 12'h02B, 12'h02C, 4'd1, 16'd50, 1'b0, 1'b0, 1'b0, 10, acc);
        repeat (3) tick();
        check("pre_reset_queue", 32'(queue_count), 32'd2);
        #2 rst = 1'b1;
        sb_q.delete();
        tb_next_id = 4'd0;
        tb_jobs = 0;
        cd = 0;
        core_done = 1'b0;
        #1 check_reset_outputs("midrun");
        tick();
        #2 rst = 1'b0;
        tick();

        // Five back-to-back jobs with the consumer stalled: FIFO fills, ids 0..4 in order.
        model_lat = 3; model_rep = 16'd3; model_ovf = 1'b0;
        cmp_ready = 1'b0;
        p0 = n_pulses;
        for (int i = 0; i < 5; i++) begin
            push_job(12'(i * 3), 12'(i * 3 + 1), 12'(i * 3 + 2), 4'd2, 16'd3, 1'b0, 1'b0,
                     1'b0, 10, acc);
            check("b2b_accept", 32'(acc), 32'd1);
        end
        check("full_queue_count", 32'(queue_count), 32'd4);
        check("full_job_ready", 32'(job_ready), 32'd0);
        push_job(12'hEEE, 12'hEEE, 12'hEEE, 4'd1, 16'd3, 1'b0, 1'b0, 1'b0, 8, acc);
        check("full_reject", 32'(acc), 32'd0);
        cmp_ready = 1'b1;
        drain(500);
        check("b2b_pulses", 32'(n_pulses - p0), 32'd5);
        check("b2b_jobs_done", 32'(jobs_done), 32'd5);

`ifdef SCHED_TIMEOUT_EN
        // Core never answers: watchdog aborts, then the next queued job still issues.
        p0 = n_pulses;
        a0 = n_aborts;
        model_lat = 0;
        push_job(12'h0AA, 12'h0BB, 12'h0CC, 4'd4, 16'(TIMEOUT), 1'b0, 1'b0, 1'b1, 10, acc);
        repeat (3) tick();
        model_lat = 5; model_rep = 16'd5; model_ovf = 1'b0;
        push_job(12'h1AA, 12'h1BB, 12'h1CC, 4'd2, 16'd5, 1'b0, 1'b0, 1'b0, 10, acc);
        drain(400);
        check("tmo_aborts", 32'(n_aborts - a0), 32'd1);
        check("tmo_pulses", 32'(n_pulses - p0), 32'd2);
`else
        a0 = n_aborts;
        check("abort_never", 32'(a0), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
